// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration over a single APB bus,
// IDLE/SETUP/ACCESS sequencing with PREADY wait states and a wait timeout.
module apb_master_arbiter #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic any_req_c;
  logic winner_c;
  logic timeout_c;
  logic complete_c;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_req_c  = req0 | req1;
    winner_c   = (req0 & req1) ? ~last_grant_q : req1;
    timeout_c  = (wait_q == CNT_W'(TIMEOUT - 1));
    complete_c = pready | timeout_c;
  end

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req_c) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (complete_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values for APB outputs, requester responses and bookkeeping.
  always_comb begin
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wait_d       = wait_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = err0_q;
    err1_d       = err1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        penable_d = 1'b0;
        if (any_req_c) begin
          psel_d       = 1'b1;
          pwrite_d     = winner_c ? wr1 : wr0;
          paddr_d      = winner_c ? addr1 : addr0;
          pwdata_d     = winner_c ? wdata1 : wdata0;
          gnt_d        = winner_c;
          last_grant_d = winner_c;
          wait_d       = '0;
        end else begin
          psel_d   = 1'b0;
          pwrite_d = 1'b0;
          paddr_d  = '0;
          pwdata_d = '0;
        end
      end
      ST_SETUP: penable_d = 1'b1;
      ST_ACCESS: begin
        if (complete_c) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
          if (!gnt_q) begin
            done0_d = 1'b1;
            err0_d  = pready ? pslverr : 1'b1;
            if (pready && !pwrite_q) rdata0_d = prdata;
          end else begin
            done1_d = 1'b1;
            err1_d  = pready ? pslverr : 1'b1;
            if (pready && !pwrite_q) rdata1_d = prdata;
          end
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wait_q       <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wait_q       <= wait_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: reset, single write, read-back,
// contention, wait states, slave error, timeout and mid-transfer reset.
module tb_apb_master_arbiter;

  logic       pclk, presetn;
  logic       req0, wr0, req1, wr1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic       psel, penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, pslverr, busy;

  int errors = 0;
  int checks = 0;

  apb_master_arbiter dut (
    .pclk(pclk), .presetn(presetn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    prdata = 0; pready = 1; pslverr = 0;
    tick(); tick();
    checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {psel, penable, pwrite}); end
    checks++; if ({paddr, pwdata} !== 12'h000) begin errors++; $display("FAIL reset_addr_data got=%h exp=000", {paddr, pwdata}); end
    checks++; if ({done0, done1, err0, err1, busy} !== 5'b0) begin errors++; $display("FAIL reset_status got=%b exp=00000", {done0, done1, err0, err1, busy}); end
    checks++; if ({rdata0, rdata1} !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", {rdata0, rdata1}); end
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req0 = 1; wr0 = 1; addr0 = 4'h1; wdata0 = 8'hAA; pready = 1;
    tick();
    checks++; if ({psel, penable, pwrite, busy} !== 4'b1011) begin errors++; $display("FAIL sw_setup got=%b exp=1011", {psel, penable, pwrite, busy}); end
    checks++; if ({paddr, pwdata} !== 12'h1AA) begin errors++; $display("FAIL sw_setup_bus got=%h exp=1aa", {paddr, pwdata}); end
    tick();
    checks++; if ({psel, penable, done0} !== 3'b110) begin errors++; $display("FAIL sw_access got=%b exp=110", {psel, penable, done0}); end
    tick();
    checks++; if ({done0, err0, done1, psel, busy} !== 5'b10000) begin errors++; $display("FAIL sw_done got=%b exp=10000", {done0, err0, done1, psel, busy}); end
    req0 = 0;
    tick();
    checks++; if ({done0, psel} !== 2'b00) begin errors++; $display("FAIL sw_done_pulse got=%b exp=00", {done0, psel}); end
  endtask

  task automatic test_readback();
    req1 = 1; wr1 = 1; addr1 = 4'h2; wdata1 = 8'h55;
    tick(); tick();
    checks++; if ({pwrite, paddr, pwdata} !== 13'h1255) begin errors++; $display("FAIL rb_write_bus got=%h exp=1255", {pwrite, paddr, pwdata}); end
    tick();
    checks++; if ({done1, err1, done0} !== 3'b100) begin errors++; $display("FAIL rb_write_done got=%b exp=100", {done1, err1, done0}); end
    req1 = 0;
    tick();
    req1 = 1; wr1 = 0; addr1 = 4'h2; prdata = 8'h55;
    tick();
    checks++; if ({psel, pwrite, paddr} !== 6'b10_0010) begin errors++; $display("FAIL rb_read_setup got=%b exp=100010", {psel, pwrite, paddr}); end
    tick(); tick();
    checks++; if ({done1, rdata1} !== 9'h155) begin errors++; $display("FAIL rb_read_done got=%h exp=155", {done1, rdata1}); end
    checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL rb_rdata0_kept got=%h exp=00", rdata0); end
    req1 = 0; prdata = 8'h00;
    tick();
  endtask

  task automatic test_contention();
    logic [11:0] exp_psel;
    logic [11:0] exp_d0;
    logic [11:0] exp_d1;
    logic [3:0]  exp_addr [4];
    int          n_setup;
    int          n0;
    int          n1;
    exp_psel = 12'b011011011011;  // bit i = cycle i+1
    exp_d0   = 12'b000100000100;
    exp_d1   = 12'b100000100000;
    exp_addr = '{4'h1, 4'h3, 4'h2, 4'h4};
    n_setup = 0; n0 = 0; n1 = 0;
    presetn = 1'b0;
    req0 = 1; wr0 = 1; addr0 = 4'h1; wdata0 = 8'h10;
    req1 = 1; wr1 = 1; addr1 = 4'h3; wdata1 = 8'h30;
    tick();
    presetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if ({psel, done0, done1} !== {exp_psel[c], exp_d0[c], exp_d1[c]}) begin errors++; $display("FAIL cont_cycle%0d got=%b exp=%b", c + 1, {psel, done0, done1}, {exp_psel[c], exp_d0[c], exp_d1[c]}); end
      if (psel && !penable && n_setup < 4) begin
        checks++; if (paddr !== exp_addr[n_setup]) begin errors++; $display("FAIL cont_grant%0d got=%h exp=%h", n_setup, paddr, exp_addr[n_setup]); end
        n_setup++;
      end
      if (done0) begin n0++; if (n0 == 2) req0 = 0; else addr0 = 4'h2; end
      if (done1) begin n1++; if (n1 == 2) req1 = 0; else addr1 = 4'h4; end
    end
    checks++; if (n_setup !== 4) begin errors++; $display("FAIL cont_grants got=%0d exp=4", n_setup); end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_wait_states();
    req0 = 1; wr0 = 0; addr0 = 4'hF; pready = 0; prdata = 8'h00;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({psel, penable, pwrite, paddr, done0} !== 8'b110_1111_0) begin errors++; $display("FAIL ws_stable%0d got=%b exp=11011110", i, {psel, penable, pwrite, paddr, done0}); end
      tick();
    end
    pready = 1; prdata = 8'h3C;
    checks++; if ({psel, penable, done0} !== 3'b110) begin errors++; $display("FAIL ws_last_access got=%b exp=110", {psel, penable, done0}); end
    tick();
    checks++; if ({done0, err0, rdata0} !== 10'b10_0011_1100) begin errors++; $display("FAIL ws_done got=%b exp=1000111100", {done0, err0, rdata0}); end
    req0 = 0; prdata = 8'h00;
    tick();
  endtask

  task automatic test_slverr();
    req0 = 1; wr0 = 1; addr0 = 4'h5; wdata0 = 8'h77; pready = 1; pslverr = 1;
    tick(); tick(); tick();
    checks++; if ({done0, err0, rdata0} !== 10'b11_0011_1100) begin errors++; $display("FAIL slverr_done got=%b exp=1100111100", {done0, err0, rdata0}); end
    req0 = 0; pslverr = 0;
    tick();
  endtask

  task automatic test_timeout();
    int acc;
    bit seen;
    acc = 0; seen = 0;
    req0 = 1; wr0 = 0; addr0 = 4'h6; pready = 0; prdata = 8'hFF;
    tick();
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done0) seen = 1;
      else if (penable) acc++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_no_done got=0 exp=1"); end
    checks++; if (acc !== 16) begin errors++; $display("FAIL to_access_cycles got=%0d exp=16", acc); end
    checks++; if ({err0, rdata0, busy, psel} !== 11'b1_0011_1100_00) begin errors++; $display("FAIL to_status got=%b exp=10011110000", {err0, rdata0, busy, psel}); end
    req0 = 0; pready = 1; prdata = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1; wr0 = 1; addr0 = 4'h7; wdata0 = 8'h11; pready = 0;
    tick(); tick();
    checks++; if ({psel, penable, busy} !== 3'b111) begin errors++; $display("FAIL rm_in_access got=%b exp=111", {psel, penable, busy}); end
    #2 presetn = 1'b0;
    #1;
    checks++; if ({psel, penable, busy} !== 3'b000) begin errors++; $display("FAIL rm_async got=%b exp=000", {psel, penable, busy}); end
    req0 = 0; req1 = 1; wr1 = 1; addr1 = 4'h8; wdata1 = 8'h88; pready = 1;
    tick();
    checks++; if ({done0, done1, psel} !== 3'b000) begin errors++; $display("FAIL rm_no_done got=%b exp=000", {done0, done1, psel}); end
    presetn = 1'b1;
    tick();
    checks++; if ({psel, paddr, pwdata} !== 13'h1888) begin errors++; $display("FAIL rm_req1_setup got=%h exp=1888", {psel, paddr, pwdata}); end
    tick(); tick();
    checks++; if ({done1, err1, done0} !== 3'b100) begin errors++; $display("FAIL rm_req1_done got=%b exp=100", {done1, err1, done0}); end
    req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Two-port APB master that shares one APB bus (4-bit address, 8-bit data) between two independent requesters, for example a test driver and a configuration sequencer. The block arbitrates with round-robin priority. It sequences the IDLE/SETUP/ACCESS phases, honours PREADY wait states, and returns read data and an error status to the requester that won the bus. It sits between the requesters and the APB slave or interconnect.

Parameters:
ADDR_W, 4, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before the block aborts the transfer and flags an error

Ports:
pclk  in  1  APB clock; all logic is on the rising edge
presetn  in  1  asynchronous active-low reset
req0 / req1  in  1  requester N has a transfer pending; must stay high until doneN
wr0 / wr1  in  1  requester N direction: 1 = write, 0 = read
addr0 / addr1  in  ADDR_W  requester N address
wdata0 / wdata1  in  DATA_W  requester N write data
done0 / done1  out  1  one-cycle pulse: requester N's transfer has completed
rdata0 / rdata1  out  DATA_W  read data for requester N; valid while doneN is high and held until N's next completion
err0 / err1  out  1  error status, valid with doneN (PSLVERR or timeout)
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset (presetn low, asynchronous) forces these values:
  - state = IDLE
  - psel, penable, pwrite = 0; paddr, pwdata = 0
  - done*, err* = 0; rdata* = 0
  - busy = 0
  - last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req is high, pick the winner and go to SETUP.
  - Capture the winner's wr, addr and wdata into the APB output registers; psel=1, penable=0.
  - If neither req is high, stay in IDLE with all APB outputs 0.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester that is not last_grant wins.
  - last_grant updates on entry to SETUP.
  - A req arriving mid-transfer waits; there is no preemption.
- SETUP: lasts exactly one cycle, then ACCESS with penable=1.
- ACCESS:
  - pwrite, paddr and pwdata stay stable for the whole phase.
  - When pready=1, the transfer completes. In that cycle the block samples prdata and pslverr, then on the next edge:
    - doneN pulses for one cycle.
    - rdataN loads prdata on reads; it is unchanged on writes.
    - errN = pslverr.
    - psel and penable drop to 0 and the FSM returns to IDLE.
  - While pready=0, the block stays in ACCESS and a wait counter increments.
  - If the counter reaches TIMEOUT, the transfer completes as an error: doneN=1, errN=1, rdataN unchanged, return to IDLE.
  - The counter clears on entry to SETUP.
- Latency: with pready tied high, req to doneN is 3 cycles (IDLE→SETUP, SETUP→ACCESS, ACCESS→IDLE and done).
- Back-to-back:
  - There is always at least one IDLE cycle between transfers (psel=0 for one cycle).
  - Sustained throughput is one transfer per 3 cycles.
- The winning requester must drop req in the cycle after doneN. If req is still high in IDLE, it is a new transfer.
- Other requester's inputs changing mid-transfer have no effect. Once captured, a transfer's wr/addr/wdata are immutable.
- If reset is asserted mid-transfer, the transfer is abandoned: psel and penable go to 0 immediately and no done is issued.
- busy = (state != IDLE).

Test Plan:
- Single write: req0 with wr0=1, addr0=4'h1, wdata0=8'hAA, pready=1 → psel high 2 cycles, penable high in cycle 2, paddr=1, pwdata=AA; done0 at cycle 3, err0=0.
- Write then read-back: write 8'h55 to 4'h2 via req1, then read 4'h2 via req1 with the slave returning the stored value → rdata1=8'h55 with done1, rdata0 unchanged.
- Contention: req0 and req1 both high from reset for two transfers each (addresses 1,2 and 3,4) → grant order 0,1,0,1; one idle cycle between each; 12 cycles total.
- Wait states: slave holds pready=0 for 3 ACCESS cycles on a read of 4'hF returning 8'h3C → APB signals stable throughout; done0 on the cycle after pready rises; rdata0=8'h3C.
- Errors:
  - pslverr=1 on a write completes with err0=1.
  - pready stuck low completes after 16 ACCESS cycles with done0=1, err0=1, and the FSM back in IDLE.
- Reset mid-ACCESS: presetn pulsed low during ACCESS → psel, penable, busy = 0 asynchronously; no done pulse; after release, req1 is serviced normally first.
